// File: rtl/xadc_pkg.sv
// XADC sampler shared constants and FSM state type.
// Imported by the sampler top and its per-slot averager.
package xadc_pkg;
  localparam int CH_W = 5;
  localparam int DRP_AW = 7;
  localparam logic [CH_W-1:0] XADC_CH_VAUX6 = 5'h16;
  localparam logic [CH_W-1:0] XADC_CH_VAUX15 = 5'h1F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEN,
    S_WAIT
  } sampler_state_t;
endpackage

// File: rtl/edge_detector_n.sv
// Rising-edge detector: registered delay compared with the live input.
// Asynchronous active-low reset.
module edge_detector_n (
  input  logic clk,
  input  logic reset_n,
  input  logic cp,
  output logic p_edge
);
  logic cp_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cp_q <= 1'b0;
    else          cp_q <= cp;
  end

  assign p_edge = cp & ~cp_q;
endmodule

// File: rtl/xadc_ch_avg.sv
// Per-slot accumulator, sample counter and averaged value register.
// Optional centre clamp enabled by defining DEADZONE_EN.
module xadc_ch_avg #(
  parameter int RES      = 7,
  parameter int AVG_LOG2 = 2,
  parameter int DEADZONE = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           we,
  input  logic [RES-1:0] sample,
  output logic [RES-1:0] value,
  output logic           upd
);
  localparam int AW = RES + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic signed [RES:0] MID = (RES+1)'(1 << (RES-1));
`ifdef DEADZONE_EN
  localparam bit DZ_ON = 1'b1;
`else
  localparam bit DZ_ON = 1'b0;
`endif

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [CW-1:0] cnt;
  logic [RES-1:0] avg;
  logic [RES-1:0] res_v;
  logic signed [RES:0] diff;
  logic signed [RES:0] adiff;

  // top RES bits of the sum are the truncated sum >> AVG_LOG2
  always_comb begin
    sum   = acc + AW'(sample);
    avg   = sum[AW-1 -: RES];
    diff  = signed'({1'b0, avg}) - MID;
    adiff = diff[RES] ? -diff : diff;
    res_v = avg;
    if (DZ_ON && (adiff <= DEADZONE))
      res_v = MID[RES-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      cnt   <= '0;
      value <= '0;
      upd   <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (we) begin
        if (cnt == LAST) begin
          value <= res_v;
          acc   <= '0;
          cnt   <= '0;
          upd   <= 1'b1;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/xadc_multi_sampler.sv
// Multi-channel XADC DRP sampler with per-slot averaging.
// Define DEADZONE_EN to clamp averages near mid-scale to the centre.
module xadc_multi_sampler
  import xadc_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int RES          = 7,
  parameter logic [CH_W*NUM_CH-1:0] CH_MAP =
    {XADC_CH_VAUX15, XADC_CH_VAUX6},
  parameter int AVG_LOG2     = 2,
  parameter int DRDY_TIMEOUT = 15,
  parameter int DEADZONE     = 4,
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  adc_eoc,
  input  logic [CH_W-1:0]       adc_channel,
  input  logic                  adc_drdy,
  input  logic [15:0]           adc_do,
  output logic                  adc_den,
  output logic [DRP_AW-1:0]     adc_daddr,
  output logic [NUM_CH*RES-1:0] value,
  output logic                  sample_valid,
  output logic [IW-1:0]         sample_idx,
  output logic                  overrun,
  output logic                  drp_timeout
);
  localparam int TW = $clog2(DRDY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(DRDY_TIMEOUT - 1);

  sampler_state_t state;
  logic eoc_edge;
  logic hit;
  logic [IW-1:0] hit_idx;
  logic [IW-1:0] slot;
  logic [TW-1:0] tmr;
  logic [NUM_CH-1:0] we;
  logic [NUM_CH-1:0] upd;
  logic [RES-1:0] sample;
  logic unused_do;

  edge_detector_n u_eoc_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .cp      (adc_eoc),
    .p_edge  (eoc_edge)
  );

  // descending scan so the lowest matching slot wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (adc_channel == CH_MAP[CH_W*i +: CH_W]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      slot        <= '0;
      tmr         <= '0;
      adc_den     <= 1'b0;
      adc_daddr   <= '0;
      overrun     <= 1'b0;
      drp_timeout <= 1'b0;
    end else begin
      adc_den     <= 1'b0;
      drp_timeout <= 1'b0;
      overrun     <= eoc_edge && (state != S_IDLE);
      unique case (state)
        S_IDLE: begin
          if (eoc_edge && hit) begin
            adc_den   <= 1'b1;
            adc_daddr <= {{(DRP_AW-CH_W){1'b0}}, adc_channel};
            slot      <= hit_idx;
            state     <= S_DEN;
          end
        end
        S_DEN: begin
          tmr   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (adc_drdy) begin
            state <= S_IDLE;
          end else if (tmr == TMR_LAST) begin
            drp_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign sample    = adc_do[15 -: RES];
  assign unused_do = ^adc_do[15-RES:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    assign we[i] = (state == S_WAIT) && adc_drdy && (slot == IW'(i));

    xadc_ch_avg #(
      .RES      (RES),
      .AVG_LOG2 (AVG_LOG2),
      .DEADZONE (DEADZONE)
    ) u_avg (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (we[i]),
      .sample  (sample),
      .value   (value[RES*i +: RES]),
      .upd     (upd[i])
    );
  end

  assign sample_valid = |upd;

  always_comb begin
    sample_idx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (upd[i]) sample_idx = IW'(i);
  end
endmodule

// File: tb/tb_xadc_multi_sampler.sv
// Bench for xadc_multi_sampler: pass-through and 4-sample instances
// driven in parallel against a sample-list model.
module tb_xadc_multi_sampler;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        adc_eoc = 1'b0;
  logic [4:0]  adc_channel = '0;
  logic        adc_drdy = 1'b0;
  logic [15:0] adc_do = '0;

  logic        den0, den1;
  logic [6:0]  daddr0, daddr1;
  logic [13:0] val0, val1;
  logic        sv0, sv1;
  logic        si0, si1;
  logic        ov0, ov1;
  logic        to0, to1;

  xadc_multi_sampler #(.AVG_LOG2(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .adc_eoc(adc_eoc),
    .adc_channel(adc_channel), .adc_drdy(adc_drdy), .adc_do(adc_do),
    .adc_den(den0), .adc_daddr(daddr0), .value(val0),
    .sample_valid(sv0), .sample_idx(si0), .overrun(ov0),
    .drp_timeout(to0)
  );

  xadc_multi_sampler dut1 (
    .clk(clk), .reset_n(reset_n), .adc_eoc(adc_eoc),
    .adc_channel(adc_channel), .adc_drdy(adc_drdy), .adc_do(adc_do),
    .adc_den(den1), .adc_daddr(daddr1), .value(val1),
    .sample_valid(sv1), .sample_idx(si1), .overrun(ov1),
    .drp_timeout(to1)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  bit cmp_en = 1'b0;

  int ev[2][2];
  int sum[2][2];
  int n[2][2];
  int evld[2];
  int eidx[2];
  int alog[2] = '{0, 2};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int dz(input int v);
`ifdef DEADZONE_EN
    if ((v - 64 <= 4) && (64 - v <= 4)) return 64;
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      evld[d] = 0;
      eidx[d] = 0;
      for (int s = 0; s < 2; s++) begin
        ev[d][s] = 0; sum[d][s] = 0; n[d][s] = 0;
      end
    end
  endtask

  task automatic model_sample(input int slot, input int s);
    if (slot < 0) return;
    for (int d = 0; d < 2; d++) begin
      sum[d][slot] += s;
      n[d][slot]++;
      if (n[d][slot] == (1 << alog[d])) begin
        ev[d][slot] = dz(sum[d][slot] >> alog[d]);
        sum[d][slot] = 0;
        n[d][slot] = 0;
        evld[d] = 1;
        eidx[d] = slot;
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int s = 0; s < 2; s++) begin
        chk($sformatf("d0_value%0d", s), int'(val0[7*s +: 7]), ev[0][s]);
        chk($sformatf("d1_value%0d", s), int'(val1[7*s +: 7]), ev[1][s]);
      end
      chk("d0_valid", int'(sv0), evld[0]);
      chk("d1_valid", int'(sv1), evld[1]);
      if (evld[0] != 0) chk("d0_idx", int'(si0), eidx[0]);
      if (evld[1] != 0) chk("d1_idx", int'(si1), eidx[1]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_den(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (den0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic read(input logic [4:0] ch, input int top,
                      input int dly, input bit ovr);
    int slot;
    bit seen;
    slot = (ch == 5'h16) ? 0 : (ch == 5'h1F) ? 1 : -1;
    adc_channel = ch;
    adc_eoc = 1'b1;
    wait_den(seen);
    chk("den_seen", int'(seen), 1);
    chk("daddr", int'(daddr0), int'(ch));
    chk("den_both", int'(den1), int'(den0));
    cyc();
    chk("den_one_cycle", int'(den0), 0);
    adc_eoc = 1'b0;
    repeat (dly - 1) cyc();
    adc_do = 16'(top << 9);
    adc_drdy = 1'b1;
    if (ovr) adc_eoc = 1'b1;
    cyc();
    model_sample(slot, top);
    adc_drdy = 1'b0;
    adc_eoc = 1'b0;
    chk("overrun", int'(ov0), int'(ovr));
    chk("overrun_d1", int'(ov1), int'(ovr));
    cyc();
    evld[0] = 0;
    evld[1] = 0;
    chk("no_extra_den", int'(den0), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int c;
    model_reset();
    repeat (3) cyc();
    chk("rst_value0", int'(val0), 0);
    chk("rst_value1", int'(val1), 0);
    chk("rst_den", int'(den0 | den1), 0);
    chk("rst_valid", int'(sv0 | sv1), 0);
    chk("rst_flags", int'(ov0 | ov1 | to0 | to1), 0);
    reset_n = 1'b1;
    cmp_en = 1'b1;
    cyc();

    read(5'h16, 7'h7F, 3, 1'b0);
    chk("t1_slot0", int'(val0[6:0]), 127);

    read(5'h1F, 10, 2, 1'b0);
    read(5'h1F, 20, 2, 1'b0);
    read(5'h1F, 30, 2, 1'b0);
    chk("t2_not_yet", int'(val1[13:7]), 0);
    read(5'h1F, 41, 2, 1'b0);
    chk("t2_avg", int'(val1[13:7]), 25);
    chk("t2_slot0_hold", int'(val1[6:0]), 0);
    chk("t2_passthru", int'(val0[13:7]), 41);

    adc_channel = 5'h03;
    adc_eoc = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("unmapped_den", int'(den0 | den1), 0);
      chk("unmapped_ovr", int'(ov0 | ov1), 0);
    end
    adc_eoc = 1'b0;
    cyc();

    adc_channel = 5'h16;
    adc_eoc = 1'b1;
    wait_den(seen);
    chk("to_den", int'(seen), 1);
    adc_eoc = 1'b0;
    c = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      c++;
      if (to0) break;
    end
    chk("to_pulse", int'(to0 & to1), 1);
    chk("to_window", int'(c >= 10 && c <= 20), 1);
    cyc();
    chk("to_one_cycle", int'(to0), 0);
    read(5'h16, 100, 2, 1'b0);

    read(5'h1F, 50, 3, 1'b1);
    chk("ovr_stored", int'(val0[13:7]), 50);
    cyc();

    repeat (6) read(5'h16, 66, 2, 1'b0);
`ifdef DEADZONE_EN
    chk("dz_66", int'(val1[6:0]), 64);
`else
    chk("dz_66", int'(val1[6:0]), 66);
`endif
    repeat (4) read(5'h16, 69, 2, 1'b0);
    chk("dz_69", int'(val1[6:0]), 69);

    adc_channel = 5'h1F;
    adc_eoc = 1'b1;
    wait_den(seen);
    chk("rst_den_seen", int'(seen), 1);
    adc_eoc = 1'b0;
    cyc();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_den", int'(den0 | den1), 0);
    chk("async_val0", int'(val0), 0);
    chk("async_val1", int'(val1), 0);
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    read(5'h16, 5, 2, 1'b0);
    chk("post_rst", int'(val0[6:0]), 5);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
